// File: rtl/npu_load_sequencer.sv
// Transmit side of the NPU write-packet protocol: one weight packet then DATA_PKTS data
// packets, payload pulled from two ready/valid sources, length-error check after every eop.
//
// state  | meaning
// IDLE   | waiting for start
// SOP    | sop visible on the active channel; first beat may already be accepted
// BEAT   | accepting payload until the packet's beat count is reached
// EOP    | eop visible on the active channel
// CHK    | err strobe of the active channel is sampled
// GAP    | inter-packet idle cycles
module npu_load_sequencer #(
    parameter int DW           = 8,
    parameter int WEIGHT_BEATS = 35,
    parameter int DATA_BEATS   = 9,
    parameter int DATA_PKTS    = 3,
    parameter int GAP          = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [1:0]    fail_pkt,
    input  logic          wt_valid,
    output logic          wt_ready,
    input  logic [DW-1:0] wt_data,
    input  logic          dt_valid,
    output logic          dt_ready,
    input  logic [DW-1:0] dt_data,
    output logic          wr_sop_weight,
    output logic          wr_vld_weight,
    output logic          wr_eop_weight,
    output logic [DW-1:0] wr_weight,
    input  logic          err_weight,
    output logic          wr_sop_data,
    output logic          wr_vld_data,
    output logic          wr_eop_data,
    output logic [DW-1:0] wr_data,
    input  logic          err_data
);

    localparam int MAXB = (WEIGHT_BEATS > DATA_BEATS) ? WEIGHT_BEATS : DATA_BEATS;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOP,
        S_BEAT,
        S_EOP,
        S_CHK,
        S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;
    logic [1:0]      pkt_idx, idx_nxt;
    logic [1:0]      fail_pkt_nxt;
    logic            busy_nxt, done_nxt, fail_nxt;
    logic            sop_nxt, vld_nxt, eop_nxt;
    logic [DW-1:0]   weight_nxt, data_nxt;

    logic            chan_w;
    logic            in_pkt;
    logic [CW-1:0]   beats;
    logic            hs;
    logic            err_act;

    assign chan_w  = (pkt_idx == 2'd0);
    assign in_pkt  = (state == S_SOP) || (state == S_BEAT);
    assign beats   = chan_w ? CW'(WEIGHT_BEATS) : CW'(DATA_BEATS);

    // Ready is cut the moment the last beat is accepted so the source is never over-read.
    assign wt_ready = in_pkt && chan_w && (cnt < beats);
    assign dt_ready = in_pkt && !chan_w && (cnt < beats);

    assign hs      = chan_w ? (wt_valid && wt_ready) : (dt_valid && dt_ready);
    assign err_act = chan_w ? err_weight : err_data;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        gap_nxt      = gap_cnt;
        idx_nxt      = pkt_idx;
        fail_pkt_nxt = fail_pkt;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        fail_nxt     = 1'b0;
        sop_nxt      = 1'b0;
        vld_nxt      = 1'b0;
        eop_nxt      = 1'b0;
        weight_nxt   = wr_weight;
        data_nxt     = wr_data;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_SOP;
                    idx_nxt      = 2'd0;
                    fail_pkt_nxt = 2'd0;
                    busy_nxt     = 1'b1;
                    cnt_nxt      = '0;
                    sop_nxt      = 1'b1;
                end
            end
            S_SOP, S_BEAT: begin
                if (hs) begin
                    cnt_nxt = cnt + CW'(1);
                    vld_nxt = 1'b1;
                    if (chan_w) begin
                        weight_nxt = wt_data;
                    end else begin
                        data_nxt = dt_data;
                    end
                end
                if (state == S_SOP) begin
                    state_nxt = S_BEAT;
                end else if (cnt == beats) begin
                    state_nxt = S_EOP;
                    eop_nxt   = 1'b1;
                end
            end
            S_EOP: begin
                state_nxt = S_CHK;
            end
            S_CHK: begin
                if (err_act) begin
                    fail_nxt     = 1'b1;
                    fail_pkt_nxt = pkt_idx;
                    busy_nxt     = 1'b0;
                    state_nxt    = S_IDLE;
                end else if (pkt_idx == 2'(DATA_PKTS)) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt = pkt_idx + 2'd1;
                    if (GAP == 0) begin
                        state_nxt = S_SOP;
                        sop_nxt   = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_GAP;
                        gap_nxt   = GW'((GAP > 0) ? GAP - 1 : 0);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_SOP;
                    sop_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            gap_cnt       <= '0;
            pkt_idx       <= 2'd0;
            fail_pkt      <= 2'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            wr_sop_weight <= 1'b0;
            wr_vld_weight <= 1'b0;
            wr_eop_weight <= 1'b0;
            wr_weight     <= '0;
            wr_sop_data   <= 1'b0;
            wr_vld_data   <= 1'b0;
            wr_eop_data   <= 1'b0;
            wr_data       <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            gap_cnt       <= gap_nxt;
            pkt_idx       <= idx_nxt;
            fail_pkt      <= fail_pkt_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            fail          <= fail_nxt;
            // sop follows the packet about to start; vld/eop follow the packet in flight
            wr_sop_weight <= sop_nxt && (idx_nxt == 2'd0);
            wr_sop_data   <= sop_nxt && (idx_nxt != 2'd0);
            wr_vld_weight <= vld_nxt && chan_w;
            wr_vld_data   <= vld_nxt && !chan_w;
            wr_eop_weight <= eop_nxt && chan_w;
            wr_eop_data   <= eop_nxt && !chan_w;
            wr_weight     <= weight_nxt;
            wr_data       <= data_nxt;
        end
    end

endmodule

// File: tb/tb_npu_load_sequencer.sv
// Scoreboard bench for npu_load_sequencer: random sources and NPU error responder,
// expected packets/payload/outcome queued per start and checked by a negedge monitor.
module tb_npu_load_sequencer;

    localparam int DW = 8;
    localparam int WB = 35;
    localparam int DB = 9;
    localparam int NP = 3;
    localparam int DONE_CODE = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [1:0]    fail_pkt;
    logic          wt_valid, wt_ready, dt_valid, dt_ready;
    logic [DW-1:0] wt_data, dt_data;
    logic          wr_sop_weight, wr_vld_weight, wr_eop_weight;
    logic          wr_sop_data, wr_vld_data, wr_eop_data;
    logic [DW-1:0] wr_weight, wr_data;
    logic          err_weight = 1'b0;
    logic          err_data = 1'b0;

    npu_load_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .fail(fail), .fail_pkt(fail_pkt),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .dt_valid(dt_valid), .dt_ready(dt_ready), .dt_data(dt_data),
        .wr_sop_weight(wr_sop_weight), .wr_vld_weight(wr_vld_weight),
        .wr_eop_weight(wr_eop_weight), .wr_weight(wr_weight), .err_weight(err_weight),
        .wr_sop_data(wr_sop_data), .wr_vld_data(wr_vld_data),
        .wr_eop_data(wr_eop_data), .wr_data(wr_data), .err_data(err_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nerr = 0;

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        ncmp++;
        nerr++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // ---------------- sources ----------------
    logic [DW-1:0] wsrc [1024];
    logic [DW-1:0] dsrc [1024];
    int wp = 0, dp = 0, mwp = 0, mdp = 0;
    int wmode = 0, dmode = 0;
    bit w_hs, d_hs;

    initial begin
        wt_valid = 1'b0; dt_valid = 1'b0; wt_data = '0; dt_data = '0;
        forever begin
            @(negedge clk);
            w_hs = rst_n && wt_valid && wt_ready;
            d_hs = rst_n && dt_valid && dt_ready;
            @(posedge clk);
            #1;
            if (w_hs) wp++;
            if (d_hs) dp++;
            case (wmode)
                0: wt_valid = 1'b1;
                1: wt_valid = ~wt_valid;
                default: wt_valid = 1'($urandom_range(0, 1));
            endcase
            case (dmode)
                0: dt_valid = 1'b1;
                1: dt_valid = ~dt_valid;
                default: dt_valid = 1'($urandom_range(0, 1));
            endcase
            wt_data = wsrc[wp % 1024];
            dt_data = dsrc[dp % 1024];
        end
    end

    // ---------------- NPU error responder ----------------
    int inj_w = 0, inj_d = 0, dcnt = 0;
    bit noise = 0;
    bit ew, ed;

    initial begin
        forever begin
            @(negedge clk);
            ew = wr_eop_weight;
            ed = wr_eop_data;
            @(posedge clk);
            #1;
            if (ed) dcnt++;
            if (ew) err_weight = (inj_w != 0);
            else    err_weight = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (ed) err_data = (dcnt == inj_d);
            else    err_data = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // ---------------- reference model ----------------
    int exp_wt[$], exp_dt[$], exp_pkt[$], exp_out[$];

    task automatic expect_run(input int iw, input int idn);
        int npk;
        exp_pkt.push_back(0);
        for (int i = 0; i < WB; i++) begin
            exp_wt.push_back(int'(wsrc[mwp % 1024]));
            mwp++;
        end
        if (iw != 0) begin
            exp_out.push_back(0);
            return;
        end
        npk = (idn > 0) ? idn : NP;
        for (int p = 0; p < npk; p++) begin
            exp_pkt.push_back(1);
            for (int i = 0; i < DB; i++) begin
                exp_dt.push_back(int'(dsrc[mdp % 1024]));
                mdp++;
            end
        end
        exp_out.push_back((idn > 0) ? idn : DONE_CODE);
    endtask

    // ---------------- monitor ----------------
    int cur_ch = 0, bcnt = 0, last_vld = 0;
    int acc_w = WB, acc_d = DB, viol = 0;
    int t_sop_w = 0, t_eop_w = 0, t_done = 0;
    int n_sop_w = 0, n_sop_d = 0, n_eop = 0, n_done = 0, n_dt_ready = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_sop_weight || wr_sop_data) begin
                check("sop_single_channel", int'(wr_sop_weight && wr_sop_data), 0);
                check("busy_during_pkt", int'(busy), 1);
                if (exp_pkt.size() == 0) flag("unexpected_sop");
                else begin
                    cur_ch = exp_pkt.pop_front();
                    check("sop_channel", int'(wr_sop_data), cur_ch);
                end
                bcnt = 0;
                if (wr_sop_weight) begin t_sop_w = cyc; acc_w = 0; n_sop_w++; end
                else begin acc_d = 0; n_sop_d++; end
            end
            if (wr_vld_weight) begin
                check("vld_w_clear_of_sop_eop", int'(wr_sop_weight || wr_eop_weight), 0);
                check("vld_w_channel", cur_ch, 0);
                if (exp_wt.size() == 0) flag("unexpected_wt_beat");
                else check("wt_payload", int'(wr_weight), exp_wt.pop_front());
                bcnt++;
                last_vld = cyc;
            end
            if (wr_vld_data) begin
                check("vld_d_clear_of_sop_eop", int'(wr_sop_data || wr_eop_data), 0);
                check("vld_d_channel", cur_ch, 1);
                if (exp_dt.size() == 0) flag("unexpected_dt_beat");
                else check("dt_payload", int'(wr_data), exp_dt.pop_front());
                bcnt++;
                last_vld = cyc;
            end
            if (wr_eop_weight || wr_eop_data) begin
                n_eop++;
                check("eop_channel", int'(wr_eop_data), cur_ch);
                check("eop_beat_count", bcnt, (cur_ch != 0) ? DB : WB);
                check("eop_after_last_beat", cyc - last_vld, 1);
                if (wr_eop_weight) t_eop_w = cyc;
            end
            if (wt_ready && (cur_ch != 0 || acc_w >= WB)) viol++;
            if (dt_ready && (cur_ch != 1 || acc_d >= DB)) viol++;
            if (wt_ready && wt_valid) acc_w++;
            if (dt_ready && dt_valid) acc_d++;
            if (dt_ready) n_dt_ready++;
            if (done || fail) begin
                check("done_fail_exclusive", int'(done && fail), 0);
                check("busy_low_at_end", int'(busy), 0);
                if (exp_out.size() == 0) flag("unexpected_outcome");
                else check("outcome", done ? DONE_CODE : int'(fail_pkt), exp_out.pop_front());
                if (done) begin t_done = cyc; n_done++; end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input int iw, input int idn, output int s);
        @(posedge clk);
        #1;
        inj_w = iw;
        inj_d = idn;
        dcnt  = 0;
        expect_run(iw, idn);
        start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_out.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_outcome_seen"}, exp_out.size(), 0);
        repeat (3) @(negedge clk);
        check({name, "_pkts_left"}, exp_pkt.size(), 0);
        check({name, "_wt_left"}, exp_wt.size(), 0);
        check({name, "_dt_left"}, exp_dt.size(), 0);
        check({name, "_ready_viol"}, viol, 0);
        check({name, "_busy_idle"}, int'(busy), 0);
    endtask

    function automatic int out_vec();
        return int'({busy, done, fail, fail_pkt, wt_ready, dt_ready,
                     wr_sop_weight, wr_vld_weight, wr_eop_weight,
                     wr_sop_data, wr_vld_data, wr_eop_data, wr_weight, wr_data});
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int s, nd0, nsd0, ndr0, ne0, n, r;
        for (int i = 0; i < 1024; i++) begin
            wsrc[i] = 8'($urandom);
            dsrc[i] = 8'($urandom);
        end
        #2 rst_n = 1'b0;
        #3;
        check("reset_outputs", out_vec(), 0);
        repeat (3) @(negedge clk);
        check("reset_outputs_held", out_vec(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // nominal timing, sources always valid
        wmode = 0; dmode = 0; noise = 0;
        nd0 = n_done;
        do_start(0, 0, s);
        wait_idle("nominal");
        check("nom_sop_w_cycle", t_sop_w - s, 1);
        check("nom_eop_w_cycle", t_eop_w - s, WB + 2);
        check("nom_done_cycle", t_done - s, 81);
        check("nom_single_done", n_done - nd0, 1);

        // weight backpressure
        wmode = 1; dmode = 2; noise = 1;
        do_start(0, 0, s);
        wait_idle("backpressure");

        // weight length error
        wmode = 2; dmode = 0; noise = 1;
        nsd0 = n_sop_d; ndr0 = n_dt_ready;
        do_start(1, 0, s);
        wait_idle("err_weight");
        check("errw_no_data_sop", n_sop_d - nsd0, 0);
        check("errw_no_dt_ready", n_dt_ready - ndr0, 0);
        check("errw_fail_pkt_held", int'(fail_pkt), 0);

        // data error on second packet, then a clean rerun
        wmode = 0; dmode = 2; noise = 0;
        nsd0 = n_sop_d;
        do_start(0, 2, s);
        wait_idle("err_data2");
        check("errd_data_pkts_sent", n_sop_d - nsd0, 2);
        repeat (5) @(negedge clk);
        check("errd_fail_pkt_held", int'(fail_pkt), 2);
        do_start(0, 0, s);
        @(negedge clk);
        check("restart_clears_fail_pkt", int'(fail_pkt), 0);
        check("restart_busy", int'(busy), 1);
        wait_idle("rerun");

        // start during data packet 1 is ignored
        wmode = 2; dmode = 2; noise = 1;
        nd0 = n_done; nsd0 = n_sop_d;
        do_start(0, 0, s);
        n = 0;
        while (!(n_sop_d > nsd0 && bcnt >= 3) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_data_beat", int'(n < 1000), 1);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_idle("start_in_beat");
        repeat (60) @(negedge clk);
        check("start_in_beat_single_done", n_done - nd0, 1);
        check("start_in_beat_no_extra_pkts", n_sop_d - nsd0, NP);

        // reset during weight beat 10
        wmode = 0; dmode = 0; noise = 0;
        do_start(0, 0, s);
        n = 0;
        while (!(cur_ch == 0 && bcnt >= 10) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_weight_beat10", int'(n < 500), 1);
        ne0 = n_eop; nd0 = n_done;
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", out_vec(), 0);
        repeat (2) @(negedge clk);
        check("reset_outputs_quiet", out_vec(), 0);
        exp_wt.delete(); exp_dt.delete(); exp_pkt.delete(); exp_out.delete();
        wp = 0; dp = 0; mwp = 0; mdp = 0;
        cur_ch = 0; bcnt = 0; acc_w = WB; acc_d = DB;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_no_eop", n_eop - ne0, 0);
        check("reset_no_done", n_done - nd0, 0);
        check("post_reset_idle", out_vec() & 32'h1fff_0000, 0);
        noise = 1; wmode = 2; dmode = 2;
        do_start(0, 0, s);
        wait_idle("post_reset");
        check("post_reset_sop_w_cycle", t_sop_w - s, 1);

        // random runs
        for (int k = 0; k < 6; k++) begin
            wmode = $urandom_range(0, 2);
            dmode = $urandom_range(0, 2);
            noise = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 5);
            if (r == 0) do_start(1, 0, s);
            else if (r <= 3) do_start(0, r, s);
            else do_start(0, 0, s);
            wait_idle("random");
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
